// File: rtl/sipo_deserializer.sv
// ============================================================================
// sipo_deserializer: serial-in/parallel-out deserializer with bit order,
// back-to-back frames, abort, busy flag and optional parity (DESER_PARITY_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sipo_deserializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             piso_start,
    input  logic             ser_in,
    input  logic             abort,
    output logic [WIDTH-1:0] prl_out,
    output logic             prl_valid,
    output logic             busy,
    output logic             parity_err
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   r_prl;
    logic               r_valid;
    logic               r_busy;
    logic               w_shift_en;
    logic               w_cnt_inc;
    logic               w_complete;
    logic               w_last;

    if (WIDTH < 2 || WIDTH > 32 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("sipo_deserializer: WIDTH must be 2..32 and PARITY_ODD 0 or 1");
    end

    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shift_nxt = {r_shift[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
        assign w_shift_nxt = {ser_in, r_shift[WIDTH-1:1]};
    end

    assign w_last = (r_cnt == c_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_complete  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (piso_start && !abort) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_shift_en = 1'b1;
                    if (w_last) begin
`ifdef DESER_PARITY_EN
                        w_state_nxt = S_PAR;
`else
                        w_complete  = 1'b1;
                        w_state_nxt = piso_start ? S_SHIFT : S_IDLE;
`endif
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
`ifdef DESER_PARITY_EN
            S_PAR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = piso_start ? S_SHIFT : S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter is only non-zero mid-frame, so every entry into SHIFT starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_inc ? r_cnt + c_CNT_W'(1) : '0;
        end
    end

`ifdef DESER_PARITY_EN
    logic r_par_err;
    logic w_par_calc;

    assign w_word     = r_shift;
    assign w_par_calc = ((^r_shift) ^ ser_in) != 1'(PARITY_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_complete & w_par_calc;
        end
    end

    assign parity_err = r_par_err;
`else
    assign w_word     = w_shift_nxt;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_prl   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= w_shift_nxt;
            end
            if (w_complete) begin
                r_prl <= w_word;
            end
            r_valid <= w_complete;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign prl_out   = r_prl;
    assign prl_valid = r_valid;
    assign busy      = r_busy;

endmodule

`default_nettype wire
